// File: rtl/bcd_seven_segment_if.sv
// Digit-side bus of one seven-segment display position: the BCD code and
// enable coming in, the segment pins, anode enable and invalid flag going out.
interface bcd_seven_segment_if;
   logic       n_enable;
   logic [3:0] bcd;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic       e;
   logic       f;
   logic       g;
   logic       AA;
   logic       invalid;

   // Digit source side: drives the code, observes the display drive.
   modport master (
      output n_enable, bcd,
      input  a, b, c, d, e, f, g, AA, invalid
   );

   // Decoder side: samples the code, drives the display.
   modport slave (
      input  n_enable, bcd,
      output a, b, c, d, e, f, g, AA, invalid
   );
endinterface

// File: rtl/bcd_seven_segment.sv
// Registered BCD-to-seven-segment decoder for a single display digit.
// One cycle of latency, one code per cycle, no state beyond the output flops.
// Codes 10-15 either blank the digit or show hex A-F (BLANK_INVALID); the
// invalid flag reports them in both cases. SEG_ACTIVE_HIGH picks pin polarity.
module bcd_seven_segment #(
   parameter bit SEG_ACTIVE_HIGH = 1'b1,
   parameter bit BLANK_INVALID   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_seven_segment_if.slave   seg_if
);

   // Pin value of a fully dark digit once polarity is applied.
   localparam logic [6:0] C_UNLIT = SEG_ACTIVE_HIGH ? 7'b000_0000 : 7'b111_1111;

   // Logical lit pattern {a,b,c,d,e,f,g}, 1 = lit.
   function automatic logic [6:0] decode_lit(input logic [3:0] code);
      logic [6:0] lit;
      lit = 7'b000_0000;
      case (code)
         4'd0:    lit = 7'b111_1110;
         4'd1:    lit = 7'b011_0000;
         4'd2:    lit = 7'b110_1101;
         4'd3:    lit = 7'b111_1001;
         4'd4:    lit = 7'b011_0011;
         4'd5:    lit = 7'b101_1011;
         4'd6:    lit = 7'b101_1111;
         4'd7:    lit = 7'b111_0000;
         4'd8:    lit = 7'b111_1111;
         4'd9:    lit = 7'b111_1011;
         4'd10:   lit = BLANK_INVALID ? 7'b000_0000 : 7'b111_0111;
         4'd11:   lit = BLANK_INVALID ? 7'b000_0000 : 7'b001_1111;
         4'd12:   lit = BLANK_INVALID ? 7'b000_0000 : 7'b100_1110;
         4'd13:   lit = BLANK_INVALID ? 7'b000_0000 : 7'b011_1101;
         4'd14:   lit = BLANK_INVALID ? 7'b000_0000 : 7'b100_1111;
         default: lit = BLANK_INVALID ? 7'b000_0000 : 7'b100_0111;
      endcase
      return lit;
   endfunction

   // Map logical lit bits onto pin levels.
   function automatic logic [6:0] to_pins(input logic [6:0] lit);
      return SEG_ACTIVE_HIGH ? lit : ~lit;
   endfunction

   logic [6:0] w_seg_pin;
   logic       w_aa;
   logic       w_invalid;

   logic [6:0] r_seg_p1;
   logic       r_aa_p1;
   logic       r_invalid_p1;

   // Next-cycle display drive from the current code and enable.
   always_comb begin
      w_seg_pin = C_UNLIT;
      w_aa      = 1'b0;
      w_invalid = 1'b0;
      if (!seg_if.n_enable) begin
         w_seg_pin = to_pins(decode_lit(seg_if.bcd));
         w_aa      = 1'b1;
         w_invalid = (seg_if.bcd > 4'd9);
      end
   end

   // ---- stage p1: output registers; reset darkens the digit at once ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg_p1     <= C_UNLIT;
         r_aa_p1      <= 1'b0;
         r_invalid_p1 <= 1'b0;
      end else begin
         r_seg_p1     <= w_seg_pin;
         r_aa_p1      <= w_aa;
         r_invalid_p1 <= w_invalid;
      end
   end

   assign seg_if.a       = r_seg_p1[6];
   assign seg_if.b       = r_seg_p1[5];
   assign seg_if.c       = r_seg_p1[4];
   assign seg_if.d       = r_seg_p1[3];
   assign seg_if.e       = r_seg_p1[2];
   assign seg_if.f       = r_seg_p1[1];
   assign seg_if.g       = r_seg_p1[0];
   assign seg_if.AA      = r_aa_p1;
   assign seg_if.invalid = r_invalid_p1;

endmodule

// File: tb/tb_bcd_seven_segment.sv
// Scoreboard bench for bcd_seven_segment. Four decoders, one per parameter
// combination, see the same stimulus; the driver queues the expected drive
// of each, and a monitor pops and compares one cycle later.
module tb_bcd_seven_segment;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcd_seven_segment_if if0 ();
   bcd_seven_segment_if if1 ();
   bcd_seven_segment_if if2 ();
   bcd_seven_segment_if if3 ();

   // k=0: active-high, blank   k=1: active-high, hex
   // k=2: active-low,  blank   k=3: active-low,  hex
   bcd_seven_segment #(.SEG_ACTIVE_HIGH(1'b1), .BLANK_INVALID(1'b1)) u0 (.clk(clk), .rst(rst), .seg_if(if0));
   bcd_seven_segment #(.SEG_ACTIVE_HIGH(1'b1), .BLANK_INVALID(1'b0)) u1 (.clk(clk), .rst(rst), .seg_if(if1));
   bcd_seven_segment #(.SEG_ACTIVE_HIGH(1'b0), .BLANK_INVALID(1'b1)) u2 (.clk(clk), .rst(rst), .seg_if(if2));
   bcd_seven_segment #(.SEG_ACTIVE_HIGH(1'b0), .BLANK_INVALID(1'b0)) u3 (.clk(clk), .rst(rst), .seg_if(if3));

   // {a,b,c,d,e,f,g,AA,invalid}
   logic [8:0] act [4];
   assign act[0] = {if0.a, if0.b, if0.c, if0.d, if0.e, if0.f, if0.g, if0.AA, if0.invalid};
   assign act[1] = {if1.a, if1.b, if1.c, if1.d, if1.e, if1.f, if1.g, if1.AA, if1.invalid};
   assign act[2] = {if2.a, if2.b, if2.c, if2.d, if2.e, if2.f, if2.g, if2.AA, if2.invalid};
   assign act[3] = {if3.a, if3.b, if3.c, if3.d, if3.e, if3.f, if3.g, if3.AA, if3.invalid};

   logic [8:0] exp_q [4][$];

   int checks = 0;
   int errors = 0;

   // Display table, straight from the digit drawings.
   localparam logic [6:0] DIGIT [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   localparam logic [6:0] HEX [6] = '{
      7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   function automatic logic [8:0] model(input int k, input logic ne, input logic [3:0] code);
      bit         sah;
      bit         blank;
      int         v;
      logic [6:0] lit;
      logic       aa;
      logic       inv;
      sah   = (k < 2);
      blank = ((k % 2) == 0);
      v     = int'(code);
      lit   = 7'b0;
      aa    = 1'b0;
      inv   = 1'b0;
      if (!ne) begin
         if (v <= 9)     lit = DIGIT[v];
         else if (blank) lit = 7'b0;
         else            lit = HEX[v - 10];
         aa  = 1'b1;
         inv = (v > 9);
      end
      return {(sah ? lit : ~lit), aa, inv};
   endfunction

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic set_in(input logic ne, input logic [3:0] code);
      if0.n_enable = ne; if0.bcd = code;
      if1.n_enable = ne; if1.bcd = code;
      if2.n_enable = ne; if2.bcd = code;
      if3.n_enable = ne; if3.bcd = code;
   endtask

   task automatic push_exp(input logic ne, input logic [3:0] code);
      for (int k = 0; k < 4; k++) exp_q[k].push_back(model(k, ne, code));
   endtask

   task automatic drive(input logic ne, input logic [3:0] code);
      @(negedge clk);
      set_in(ne, code);
      push_exp(ne, code);
   endtask

   function automatic bit all_empty();
      return (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
             (exp_q[2].size() == 0) && (exp_q[3].size() == 0);
   endfunction

   task automatic drain();
      for (int i = 0; i < 10 && !all_empty(); i++) @(negedge clk);
      checks++;
      if (!all_empty()) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q[0].size());
         for (int k = 0; k < 4; k++) exp_q[k].delete();
      end
   endtask

   task automatic check_reset(input string name);
      for (int k = 0; k < 4; k++)
         check($sformatf("%s_inst%0d", name, k), act[k], model(k, 1'b1, 4'd0));
   endtask

   // Monitor: outputs settle just after each edge; compare against the queue.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (exp_q[k].size() > 0) begin
               logic [8:0] e;
               e = exp_q[k].pop_front();
               check($sformatf("out_inst%0d", k), act[k], e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      set_in(1'b1, 4'd0);
      #12;
      check_reset("reset_init");
      @(negedge clk);
      rst = 1'b0;

      // Digit sweep, disable/enable, invalid codes, simultaneous change.
      for (int d = 0; d < 10; d++) drive(1'b0, 4'(d));
      drive(1'b1, 4'd5);
      drive(1'b0, 4'd5);
      drive(1'b0, 4'd15);
      drive(1'b0, 4'd10);
      drive(1'b1, 4'd9);
      drive(1'b0, 4'd0);

      // Randomised codes with occasional disable.
      repeat (300) drive(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      drain();

      // Asynchronous reset in the middle of a low clock phase.
      drive(1'b0, 4'd8);
      drain();
      #3;
      rst = 1'b1;
      #1;
      check_reset("reset_async");
      @(posedge clk);
      #1;
      check_reset("reset_hold");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset("reset_release");
      push_exp(1'b0, 4'd8);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
